// File: rtl/voice_allocator_pkg.sv
// Shared types for the voice allocator: per-voice state, controller FSM
// states and default widths.
package voice_allocator_pkg;

  localparam int unsigned NUM_VOICES_DEF = 4;
  localparam int unsigned KEY_W_DEF      = 7;
  localparam int unsigned PERIOD_W_DEF   = 23;

  typedef enum logic [1:0] {
    VS_FREE      = 2'd0,
    VS_HELD      = 2'd1,
    VS_RELEASING = 2'd2
  } vstate_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_ISSUE  = 2'd2
  } fsm_t;

endpackage

// File: rtl/voice_allocator_if.sv
// Note-event handshake between the event source (master) and the voice
// allocator (slave).
//   ev_valid  event offered
//   ev_ready  event accepted when ev_valid & ev_ready
//   ev_is_on  1 = note-on, 0 = note-off
//   ev_key    key number
//   ev_period oscillator period (ignored for note-off)
interface voice_allocator_if
  import voice_allocator_pkg::*;
#(
  parameter int unsigned KEY_W    = KEY_W_DEF,
  parameter int unsigned PERIOD_W = PERIOD_W_DEF
);
  logic                ev_valid;
  logic                ev_ready;
  logic                ev_is_on;
  logic [KEY_W-1:0]    ev_key;
  logic [PERIOD_W-1:0] ev_period;

  modport master (output ev_valid, ev_is_on, ev_key, ev_period, input ev_ready);
  modport slave  (input ev_valid, ev_is_on, ev_key, ev_period, output ev_ready);
endinterface

// File: rtl/voice_allocator_pick.sv
// voice_pick: combinational voice selection for one event.
//   state/key/rank  per-voice state, key and LRU rank (0 = newest)
//   ev_key/ev_is_on event being looked up
//   sel_idx         chosen voice
//   sel_valid       a voice was chosen (always for note-on)
//   sel_steal       note-on took a busy voice that held a different key
// Note-on priority: same key (HELD/RELEASING) -> lowest free -> oldest
// RELEASING -> oldest HELD. Note-off only matches a HELD voice.
module voice_pick
  import voice_allocator_pkg::*;
#(
  parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
  parameter int unsigned KEY_W      = KEY_W_DEF,
  parameter int unsigned IDX_W      = $clog2(NUM_VOICES)
) (
  input  vstate_t [NUM_VOICES-1:0]            state,
  input  logic    [NUM_VOICES-1:0][KEY_W-1:0] key,
  input  logic    [NUM_VOICES-1:0][IDX_W-1:0] rank,
  input  logic    [KEY_W-1:0]                 ev_key,
  input  logic                                ev_is_on,
  output logic    [IDX_W-1:0]                 sel_idx,
  output logic                                sel_valid,
  output logic                                sel_steal
);

  logic             w_match_hit, w_free_hit, w_rel_hit, w_held_hit;
  logic [IDX_W-1:0] w_match_idx, w_free_idx, w_rel_idx, w_held_idx;

  always_comb begin
    w_match_hit = 1'b0;
    w_free_hit  = 1'b0;
    w_rel_hit   = 1'b0;
    w_held_hit  = 1'b0;
    w_match_idx = '0;
    w_free_idx  = '0;
    w_rel_idx   = '0;
    w_held_idx  = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (!w_match_hit && state[IDX_W'(i)] != VS_FREE && key[IDX_W'(i)] == ev_key &&
          (ev_is_on || state[IDX_W'(i)] == VS_HELD)) begin
        w_match_hit = 1'b1;
        w_match_idx = IDX_W'(i);
      end
      if (!w_free_hit && state[IDX_W'(i)] == VS_FREE) begin
        w_free_hit = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (state[IDX_W'(i)] == VS_RELEASING &&
          (!w_rel_hit || rank[IDX_W'(i)] > rank[w_rel_idx])) begin
        w_rel_hit = 1'b1;
        w_rel_idx = IDX_W'(i);
      end
      if (state[IDX_W'(i)] == VS_HELD &&
          (!w_held_hit || rank[IDX_W'(i)] > rank[w_held_idx])) begin
        w_held_hit = 1'b1;
        w_held_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    sel_idx   = '0;
    sel_valid = 1'b0;
    sel_steal = 1'b0;
    if (w_match_hit) begin
      sel_idx   = w_match_idx;
      sel_valid = 1'b1;
    end else if (ev_is_on) begin
      sel_valid = 1'b1;
      if (w_free_hit) begin
        sel_idx = w_free_idx;
      end else if (w_rel_hit) begin
        sel_idx   = w_rel_idx;
        sel_steal = 1'b1;
      end else begin
        sel_idx   = w_held_idx;
        sel_steal = w_held_hit;
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: polyphony controller assigning note events to voices.
//   clk_fast        sole clock
//   rst             synchronous active-high reset
//   ev              note-event handshake (slave side)
//   voice_done      per-voice release complete
//   voice_note_on   1-cycle note-on pulse per voice
//   voice_note_off  1-cycle note-off pulse per voice
//   voice_period    per-voice period, voice i at [i*PERIOD_W +: PERIOD_W]
//   voice_busy      voice state != FREE
//   steal           1-cycle pulse when a note-on steals a voice
// Event accepted at edge T -> pulse visible in cycle T+2; next accept T+3.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
  parameter int unsigned KEY_W      = KEY_W_DEF,
  parameter int unsigned PERIOD_W   = PERIOD_W_DEF
) (
  input  logic                           clk_fast,
  input  logic                           rst,
  voice_allocator_if.slave               ev,
  input  logic [NUM_VOICES-1:0]          voice_done,
  output logic [NUM_VOICES-1:0]          voice_note_on,
  output logic [NUM_VOICES-1:0]          voice_note_off,
  output logic [NUM_VOICES*PERIOD_W-1:0] voice_period,
  output logic [NUM_VOICES-1:0]          voice_busy,
  output logic                           steal
);

  localparam int unsigned IDX_W = $clog2(NUM_VOICES);

  fsm_t r_fsm, w_fsm_nxt;
  logic w_accept, w_issue_on, w_issue_off;

  logic                r_ev_is_on;
  logic [KEY_W-1:0]    r_ev_key;
  logic [PERIOD_W-1:0] r_ev_period;

  logic [IDX_W-1:0] w_sel_idx, r_sel_idx;
  logic             w_sel_valid, r_sel_valid;
  logic             w_sel_steal, r_sel_steal;

  vstate_t [NUM_VOICES-1:0]               r_state;
  logic    [NUM_VOICES-1:0][KEY_W-1:0]    r_key;
  logic    [NUM_VOICES-1:0][IDX_W-1:0]    r_rank;
  logic    [NUM_VOICES-1:0][PERIOD_W-1:0] r_period;
  logic    [NUM_VOICES-1:0]               r_note_on, r_note_off;
  logic                                   r_steal;

  // Ready is gated by rst so no event is accepted while reset is held.
  assign ev.ev_ready = (r_fsm == ST_IDLE) && !rst;
  assign w_accept    = ev.ev_valid && ev.ev_ready;

  always_ff @(posedge clk_fast) begin
    if (rst) r_fsm <= ST_IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_issue_on  = 1'b0;
    w_issue_off = 1'b0;
    case (r_fsm)
      ST_IDLE:   if (w_accept) w_fsm_nxt = ST_LOOKUP;
      ST_LOOKUP: w_fsm_nxt = ST_ISSUE;
      ST_ISSUE: begin
        w_fsm_nxt   = ST_IDLE;
        w_issue_on  = r_sel_valid && r_ev_is_on;
        w_issue_off = r_sel_valid && !r_ev_is_on;
      end
      default:   w_fsm_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      r_ev_is_on  <= 1'b0;
      r_ev_key    <= '0;
      r_ev_period <= '0;
    end else if (w_accept) begin
      r_ev_is_on  <= ev.ev_is_on;
      r_ev_key    <= ev.ev_key;
      r_ev_period <= ev.ev_period;
    end
  end

  voice_pick #(
    .NUM_VOICES (NUM_VOICES),
    .KEY_W      (KEY_W),
    .IDX_W      (IDX_W)
  ) u_pick (
    .state     (r_state),
    .key       (r_key),
    .rank      (r_rank),
    .ev_key    (r_ev_key),
    .ev_is_on  (r_ev_is_on),
    .sel_idx   (w_sel_idx),
    .sel_valid (w_sel_valid),
    .sel_steal (w_sel_steal)
  );

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      r_sel_idx   <= '0;
      r_sel_valid <= 1'b0;
      r_sel_steal <= 1'b0;
    end else if (r_fsm == ST_LOOKUP) begin
      r_sel_idx   <= w_sel_idx;
      r_sel_valid <= w_sel_valid;
      r_sel_steal <= w_sel_steal;
    end
  end

  // The ISSUE update is written after the release-complete update so a
  // note-on to a voice finishing its release in the same cycle wins.
  always_ff @(posedge clk_fast) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        r_state[IDX_W'(i)] <= VS_FREE;
        r_rank[IDX_W'(i)]  <= IDX_W'(i);
      end
      r_key      <= '0;
      r_period   <= '0;
      r_note_on  <= '0;
      r_note_off <= '0;
      r_steal    <= 1'b0;
    end else begin
      r_note_on  <= '0;
      r_note_off <= '0;
      r_steal    <= 1'b0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        if (r_state[IDX_W'(i)] == VS_RELEASING && voice_done[IDX_W'(i)])
          r_state[IDX_W'(i)] <= VS_FREE;
      end
      if (w_issue_on) begin
        r_note_on[r_sel_idx] <= 1'b1;
        r_steal              <= r_sel_steal;
        r_state[r_sel_idx]   <= VS_HELD;
        r_key[r_sel_idx]     <= r_ev_key;
        r_period[r_sel_idx]  <= r_ev_period;
        // Move the chosen voice to newest; only voices younger than it age.
        for (int unsigned j = 0; j < NUM_VOICES; j++) begin
          if (IDX_W'(j) == r_sel_idx)
            r_rank[IDX_W'(j)] <= '0;
          else if (r_rank[IDX_W'(j)] < r_rank[r_sel_idx])
            r_rank[IDX_W'(j)] <= r_rank[IDX_W'(j)] + 1'b1;
        end
      end
      if (w_issue_off) begin
        r_note_off[r_sel_idx] <= 1'b1;
        r_state[r_sel_idx]    <= VS_RELEASING;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_VOICES; i++)
      voice_busy[IDX_W'(i)] = (r_state[IDX_W'(i)] != VS_FREE);
  end

  assign voice_note_on  = r_note_on;
  assign voice_note_off = r_note_off;
  assign voice_period   = r_period;
  assign steal          = r_steal;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: table of events with hand-derived expected
// pulses/busy, checked through a scoreboard at the pulse cycle, plus
// sequences for reset in LOOKUP and voice_done colliding with a note-on.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int KW = 7;
  localparam int PW = 23;

  logic             clk_fast = 1'b0;
  logic             rst      = 1'b1;
  logic [NV-1:0]    voice_done = '0;
  logic [NV-1:0]    voice_note_on, voice_note_off, voice_busy;
  logic [NV*PW-1:0] voice_period;
  logic             steal;

  voice_allocator_if #(.KEY_W(KW), .PERIOD_W(PW)) ev_if ();

  voice_allocator #(.NUM_VOICES(NV), .KEY_W(KW), .PERIOD_W(PW)) dut (
    .clk_fast       (clk_fast),
    .rst            (rst),
    .ev             (ev_if),
    .voice_done     (voice_done),
    .voice_note_on  (voice_note_on),
    .voice_note_off (voice_note_off),
    .voice_period   (voice_period),
    .voice_busy     (voice_busy),
    .steal          (steal)
  );

  always #5 clk_fast = ~clk_fast;

  typedef struct {
    logic          do_rst;
    logic [NV-1:0] done_before;
    logic          is_on;
    logic [KW-1:0] key;
    logic [PW-1:0] period;
    logic [NV-1:0] exp_on;
    logic [NV-1:0] exp_off;
    logic          exp_steal;
    logic [NV-1:0] exp_busy;
  } vec_t;

  typedef struct {
    int unsigned   due;
    logic [NV-1:0] on;
    logic [NV-1:0] off;
    logic          stl;
    logic [NV-1:0] busy;
    logic [PW-1:0] period;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always @(posedge clk_fast) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic vec_t mk(input logic r, input logic [NV-1:0] d, input logic on,
                              input int k, input int p, input logic [NV-1:0] eon,
                              input logic [NV-1:0] eoff, input logic es, input logic [NV-1:0] eb);
    vec_t v;
    v.do_rst = r; v.done_before = d; v.is_on = on; v.key = KW'(k); v.period = PW'(p);
    v.exp_on = eon; v.exp_off = eoff; v.exp_steal = es; v.exp_busy = eb;
    return v;
  endfunction

  // Scoreboard consumer: compares at the pulse cycle, otherwise no pulse allowed.
  always @(negedge clk_fast) begin
    exp_t e;
    if (!rst) begin
      if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("note_on", 32'(voice_note_on), 32'(e.on));
        chk("note_off", 32'(voice_note_off), 32'(e.off));
        chk("steal", 32'(steal), 32'(e.stl));
        chk("busy", 32'(voice_busy), 32'(e.busy));
        for (int i = 0; i < NV; i++)
          if (e.on[i]) chk("period", 32'(voice_period[i*PW +: PW]), 32'(e.period));
      end else if (voice_note_on != '0 || voice_note_off != '0 || steal) begin
        chk("spurious_pulse", {23'd0, voice_note_on, voice_note_off, steal}, 32'd0);
      end
    end
  end

  task automatic send(input logic on, input logic [KW-1:0] k, input logic [PW-1:0] p,
                      input logic [NV-1:0] eon, input logic [NV-1:0] eoff,
                      input logic es, input logic [NV-1:0] eb);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk_fast);
    ev_if.ev_valid  = 1'b1;
    ev_if.ev_is_on  = on;
    ev_if.ev_key    = k;
    ev_if.ev_period = p;
    while (!ev_if.ev_ready && n < 50) begin
      @(negedge clk_fast);
      n++;
    end
    if (!ev_if.ev_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      ev_if.ev_valid = 1'b0;
      return;
    end
    e.due = cyc + 3; e.on = eon; e.off = eoff; e.stl = es; e.busy = eb; e.period = p;
    sb.push_back(e);
    @(posedge clk_fast);
    @(negedge clk_fast);
    ev_if.ev_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk_fast);
    while ((sb.size() != 0 || !ev_if.ev_ready) && n < 20) begin
      @(negedge clk_fast);
      n++;
    end
    if (sb.size() != 0 || !ev_if.ev_ready) begin
      chk("idle_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk_fast);
    rst = 1'b1;
    voice_done = '0;
    ev_if.ev_valid = 1'b0;
    repeat (2) @(negedge clk_fast);
    chk("ready_in_rst", 32'(ev_if.ev_ready), 32'd0);
    sb.delete();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(ev_if.ev_ready), 32'd1);
    chk("busy_after_rst", 32'(voice_busy), 32'd0);
    chk("pulses_after_rst", {29'd0, |voice_note_on, |voice_note_off, steal}, 32'd0);
    chk("period_after_rst", 32'(|voice_period), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    ev_if.ev_valid = 1'b0; ev_if.ev_is_on = 1'b0; ev_if.ev_key = '0; ev_if.ev_period = '0;

    //            rst  done  on key  period  exp_on   exp_off  stl busy
    vecs.push_back(mk(1, 4'b0000, 1, 60, 1000, 4'b0001, 4'b0000, 0, 4'b0001));
    vecs.push_back(mk(0, 4'b0000, 1, 62, 2000, 4'b0010, 4'b0000, 0, 4'b0011));
    vecs.push_back(mk(0, 4'b0000, 1, 64, 3000, 4'b0100, 4'b0000, 0, 4'b0111));
    vecs.push_back(mk(0, 4'b0000, 1, 65, 4000, 4'b1000, 4'b0000, 0, 4'b1111));
    vecs.push_back(mk(0, 4'b0000, 1, 67, 5000, 4'b0001, 4'b0000, 1, 4'b1111));
    vecs.push_back(mk(0, 4'b0000, 1, 69, 6000, 4'b0010, 4'b0000, 1, 4'b1111));
    vecs.push_back(mk(0, 4'b0000, 0, 64, 0,    4'b0000, 4'b0100, 0, 4'b1111));
    vecs.push_back(mk(0, 4'b0000, 1, 71, 7000, 4'b0100, 4'b0000, 1, 4'b1111));
    vecs.push_back(mk(0, 4'b0000, 0, 65, 0,    4'b0000, 4'b1000, 0, 4'b1111));
    vecs.push_back(mk(0, 4'b0000, 0, 65, 0,    4'b0000, 4'b0000, 0, 4'b1111));
    vecs.push_back(mk(0, 4'b1000, 1, 72, 8000, 4'b1000, 4'b0000, 0, 4'b1111));
    vecs.push_back(mk(0, 4'b0000, 1, 67, 9000, 4'b0001, 4'b0000, 0, 4'b1111));
    vecs.push_back(mk(0, 4'b0000, 0, 70, 0,    4'b0000, 4'b0000, 0, 4'b1111));
    vecs.push_back(mk(0, 4'b0000, 0, 67, 0,    4'b0000, 4'b0001, 0, 4'b1111));
    vecs.push_back(mk(0, 4'b0000, 1, 67, 123,  4'b0001, 4'b0000, 0, 4'b1111));
    vecs.push_back(mk(0, 4'b0000, 0, 69, 0,    4'b0000, 4'b0010, 0, 4'b1111));
    vecs.push_back(mk(0, 4'b0000, 0, 71, 0,    4'b0000, 4'b0100, 0, 4'b1111));
    vecs.push_back(mk(0, 4'b0000, 1, 74, 4242, 4'b0010, 4'b0000, 1, 4'b1111));
    vecs.push_back(mk(1, 4'b0000, 1, 60, 1000, 4'b0001, 4'b0000, 0, 4'b0001));
    vecs.push_back(mk(0, 4'b0000, 0, 60, 0,    4'b0000, 4'b0001, 0, 4'b0001));
    vecs.push_back(mk(0, 4'b0000, 1, 63, 777,  4'b0010, 4'b0000, 0, 4'b0011));
    vecs.push_back(mk(0, 4'b0011, 1, 62, 1500, 4'b0001, 4'b0000, 0, 4'b0011));
    vecs.push_back(mk(0, 4'b0000, 1, 62, 500,  4'b0001, 4'b0000, 0, 4'b0011));
    vecs.push_back(mk(0, 4'b0000, 0, 70, 0,    4'b0000, 4'b0000, 0, 4'b0011));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_rst) do_reset();
      wait_idle();
      if (vecs[i].done_before != '0) begin
        @(negedge clk_fast);
        voice_done = vecs[i].done_before;
        @(negedge clk_fast);
        voice_done = '0;
      end
      send(vecs[i].is_on, vecs[i].key, vecs[i].period, vecs[i].exp_on,
           vecs[i].exp_off, vecs[i].exp_steal, vecs[i].exp_busy);
    end
    wait_idle();

    // voice_done on the voice receiving a note-on in its ISSUE cycle.
    send(1'b0, 7'd62, 23'd0, 4'b0000, 4'b0001, 1'b0, 4'b0011);
    wait_idle();
    send(1'b1, 7'd62, 23'd321, 4'b0001, 4'b0000, 1'b0, 4'b0011);
    @(negedge clk_fast);
    voice_done = 4'b0001;
    @(negedge clk_fast);
    voice_done = '0;
    @(negedge clk_fast);
    chk("done_vs_issue_busy", 32'(voice_busy), 32'h3);
    wait_idle();

    // Reset asserted while a note-on is in LOOKUP.
    @(negedge clk_fast);
    ev_if.ev_valid = 1'b1; ev_if.ev_is_on = 1'b1; ev_if.ev_key = 7'd90; ev_if.ev_period = 23'd55;
    chk("ready_before_accept", 32'(ev_if.ev_ready), 32'd1);
    @(posedge clk_fast);
    @(negedge clk_fast);
    ev_if.ev_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("ready_during_rst", 32'(ev_if.ev_ready), 32'd0);
    @(negedge clk_fast);
    chk("rst_lookup_busy", 32'(voice_busy), 32'd0);
    chk("rst_lookup_on", 32'(voice_note_on), 32'd0);
    chk("rst_lookup_steal", 32'(steal), 32'd0);
    chk("rst_lookup_period", 32'(|voice_period), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_lookup_ready", 32'(ev_if.ev_ready), 32'd1);
    repeat (3) begin
      @(negedge clk_fast);
      chk("rst_lookup_no_pulse", {30'd0, |voice_note_on, |voice_note_off}, 32'd0);
    end

    send(1'b1, 7'd60, 23'd1000, 4'b0001, 4'b0000, 1'b0, 4'b0001);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
